// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: ALU codes, opcode/funct
// constants, FSM state codes and the decoded instruction classes.
package mc_ctrl_pkg;

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_RTYPE   = 4'd1,
        CLS_LW      = 4'd2,
        CLS_SW      = 4'd3,
        CLS_BEQ     = 4'd4,
        CLS_BNE     = 4'd5,
        CLS_IALU    = 4'd6,
        CLS_J       = 4'd7,
        CLS_JAL     = 4'd8
    } iclass_e;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: op/funct to instruction class,
// ALU operation for R-type and immediate ALU forms, extension mode, legality.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output iclass_e    iclass_o,
    output logic [3:0] alu_op_o,
    output logic       ext_op_o,
    output logic       legal_o
);

    always_comb begin
        iclass_o = CLS_ILLEGAL;
        alu_op_o = ALU_NOP;
        ext_op_o = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                iclass_o = CLS_RTYPE;
                case (funct_i)
                    FN_ADDU: alu_op_o = ALU_ADD;
                    FN_SUBU: alu_op_o = ALU_SUB;
                    FN_AND:  alu_op_o = ALU_AND;
                    FN_OR:   alu_op_o = ALU_OR;
                    FN_NOR:  alu_op_o = ALU_NOR;
                    FN_SLT:  alu_op_o = ALU_SLT;
                    FN_SLTU: alu_op_o = ALU_SLTU;
                    default: iclass_o = CLS_ILLEGAL;
                endcase
            end
            OP_LW:   iclass_o = CLS_LW;
            OP_SW:   iclass_o = CLS_SW;
            OP_BEQ:  iclass_o = CLS_BEQ;
            OP_BNE:  iclass_o = CLS_BNE;
            OP_J:    iclass_o = CLS_J;
            OP_JAL:  iclass_o = CLS_JAL;
            OP_ADDI: begin
                iclass_o = CLS_IALU;
                alu_op_o = ALU_ADD;
                ext_op_o = 1'b1;
            end
            OP_SLTI: begin
                iclass_o = CLS_IALU;
                alu_op_o = ALU_SLT;
                ext_op_o = 1'b1;
            end
            // Logical immediates are zero-extended.
            OP_ANDI: begin
                iclass_o = CLS_IALU;
                alu_op_o = ALU_AND;
            end
            OP_ORI: begin
                iclass_o = CLS_IALU;
                alu_op_o = ALU_OR;
            end
            default: iclass_o = CLS_ILLEGAL;
        endcase
        legal_o = (iclass_o != CLS_ILLEGAL);
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset control unit: Moore FSM producing datapath enables
// and muxing selects; op/funct are the IR fields and are stable after FETCH.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [3:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_op,
    output logic       ior_d,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       illegal,
    output logic [3:0] state
);

    state_e     state_q, state_d;
    iclass_e    dec_class;
    logic [3:0] dec_alu_op;
    logic       dec_ext_op;
    logic       dec_legal;

    logic       ir_write_c, mem_write_c, reg_write_c, pc_write_c, illegal_c;

    mc_decode u_decode (
        .op_i     (op),
        .funct_i  (funct),
        .iclass_o (dec_class),
        .alu_op_o (dec_alu_op),
        .ext_op_o (dec_ext_op),
        .legal_o  (dec_legal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = S_FETCH;
        alu_op      = ALU_NOP;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'd0;
        ext_op      = 1'b0;
        ior_d       = 1'b0;
        ir_write_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        reg_dst     = 2'd0;
        mem_to_reg  = 2'd0;
        pc_write_c  = 1'b0;
        pc_source   = 2'd0;
        illegal_c   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write_c = 1'b1;
                alu_src_b  = 2'd1;
                alu_op     = ALU_ADD;
                pc_write_c = 1'b1;
                state_d    = S_DECODE;
            end
            // Speculatively compute the branch target into ALUOut.
            S_DECODE: begin
                alu_src_b = 2'd3;
                ext_op    = 1'b1;
                alu_op    = ALU_ADD;
                if (!dec_legal) begin
                    illegal_c = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    case (dec_class)
                        CLS_LW, CLS_SW:   state_d = S_MEMADR;
                        CLS_RTYPE:        state_d = S_EXEC;
                        CLS_BEQ, CLS_BNE: state_d = S_BRANCH;
                        CLS_IALU:         state_d = S_IEXEC;
                        CLS_J, CLS_JAL:   state_d = S_JUMP;
                        default:          state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                ext_op    = 1'b1;
                alu_op    = ALU_ADD;
                state_d   = (dec_class == CLS_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ior_d   = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write_c = 1'b1;
                mem_to_reg  = 2'd1;
                state_d     = S_FETCH;
            end
            S_MEMWR: begin
                ior_d       = 1'b1;
                mem_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = dec_alu_op;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                reg_dst     = 2'd1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_SUB;
                pc_source  = 2'd1;
                pc_write_c = (dec_class == CLS_BNE) ? ~zero : zero;
                state_d    = S_FETCH;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = dec_alu_op;
                ext_op    = dec_ext_op;
                state_d   = S_IWB;
            end
            S_IWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            // PC already holds PC+4 here, which is the jal link value.
            S_JUMP: begin
                pc_source  = 2'd2;
                pc_write_c = 1'b1;
                if (dec_class == CLS_JAL) begin
                    reg_write_c = 1'b1;
                    reg_dst     = 2'd2;
                    mem_to_reg  = 2'd2;
                end
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Architectural side effects are suppressed for the whole reset cycle.
    assign ir_write  = ir_write_c  & ~rst;
    assign mem_write = mem_write_c & ~rst;
    assign reg_write = reg_write_c & ~rst;
    assign pc_write  = pc_write_c  & ~rst;
    assign illegal   = illegal_c   & ~rst;
    assign state     = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle expected output vectors are queued
// for each instruction and compared as the FSM walks through its states.
module tb_mc_ctrl;
    import mc_ctrl_pkg::*;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op;
    logic       ior_d;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       illegal;
    logic [3:0] state;

    int checks;
    int failures;
    logic [23:0] exp_q[$];
    logic [23:0] obs;

    mc_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ext_op     (ext_op),
        .ior_d      (ior_d),
        .ir_write   (ir_write),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .pc_write   (pc_write),
        .pc_source  (pc_source),
        .illegal    (illegal),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {state, alu_op, alu_src_a, alu_src_b, ext_op, ior_d, ir_write,
                  mem_write, reg_write, reg_dst, mem_to_reg, pc_write, pc_source, illegal};

    function automatic logic [23:0] mk(
        input logic [3:0] st, input logic [3:0] aop, input logic sa,
        input logic [1:0] sb, input logic ext, input logic iord, input logic irw,
        input logic mw, input logic rw, input logic [1:0] rd,
        input logic [1:0] m2r, input logic pw, input logic [1:0] ps, input logic ill);
        return {st, aop, sa, sb, ext, iord, irw, mw, rw, rd, m2r, pw, ps, ill};
    endfunction

    task automatic push_fetch();
        exp_q.push_back(mk(4'd0, ALU_ADD, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                           2'd0, 2'd0, 1'b1, 2'd0, 1'b0));
    endtask

    task automatic push_decode(input logic ill);
        exp_q.push_back(mk(4'd1, ALU_ADD, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                           2'd0, 2'd0, 1'b0, 2'd0, ill));
    endtask

    task automatic push_exec(input logic [3:0] aop);
        exp_q.push_back(mk(4'd6, aop, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                           2'd0, 2'd0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(mk(4'd7, ALU_NOP, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                           2'd1, 2'd0, 1'b0, 2'd0, 1'b0));
    endtask

    task automatic push_iexec(input logic [3:0] aop, input logic ext);
        exp_q.push_back(mk(4'd9, aop, 1'b1, 2'd2, ext, 1'b0, 1'b0, 1'b0, 1'b0,
                           2'd0, 2'd0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(mk(4'd10, ALU_NOP, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                           2'd0, 2'd0, 1'b0, 2'd0, 1'b0));
    endtask

    task automatic push_branch(input logic pw);
        exp_q.push_back(mk(4'd8, ALU_SUB, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                           2'd0, 2'd0, pw, 2'd1, 1'b0));
    endtask

    task automatic push_jump(input logic link);
        exp_q.push_back(mk(4'd11, ALU_NOP, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, link,
                           link ? 2'd2 : 2'd0, link ? 2'd2 : 2'd0, 1'b1, 2'd2, 1'b0));
    endtask

    task automatic push_memadr();
        exp_q.push_back(mk(4'd2, ALU_ADD, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                           2'd0, 2'd0, 1'b0, 2'd0, 1'b0));
    endtask

    task automatic check_vec(input string tag, input logic [23:0] e);
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic check_state(input string tag, input logic [3:0] e);
        checks++;
        assert (state === e) else begin
            failures++;
            $error("FAIL %s state observed=%0d expected=%0d", tag, state, e);
        end
    endtask

    task automatic check_rst_quiet(input string tag);
        checks++;
        assert ({pc_write, ir_write, mem_write, reg_write, illegal} === 5'b0) else begin
            failures++;
            $error("FAIL %s enables observed=%b expected=00000", tag,
                   {pc_write, ir_write, mem_write, reg_write, illegal});
        end
    endtask

    // Drive one instruction and pop/compare one expected vector per cycle.
    task automatic run_instr(input string tag, input logic [5:0] o,
                             input logic [5:0] f, input logic z);
        logic [23:0] e;
        int cyc;
        op = o;
        funct = f;
        zero = z;
        #1;
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_vec($sformatf("%s_c%0d", tag, cyc), e);
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        op = 6'h3F;
        funct = 6'h00;
        zero = 1'b0;

        @(posedge clk);
        #1;
        check_rst_quiet("reset_c0");
        check_state("reset_c0", 4'd0);
        @(posedge clk);
        #1;
        check_rst_quiet("reset_c1");
        check_state("reset_c1", 4'd0);
        rst = 1'b0;

        push_fetch(); push_decode(1'b0); push_memadr();
        exp_q.push_back(mk(4'd3, ALU_NOP, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                           2'd0, 2'd0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(mk(4'd4, ALU_NOP, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                           2'd0, 2'd1, 1'b0, 2'd0, 1'b0));
        run_instr("lw", OP_LW, 6'h00, 1'b0);

        push_fetch(); push_decode(1'b0); push_branch(1'b1);
        run_instr("beq_z1", OP_BEQ, 6'h00, 1'b1);
        push_fetch(); push_decode(1'b0); push_branch(1'b0);
        run_instr("beq_z0", OP_BEQ, 6'h00, 1'b0);
        push_fetch(); push_decode(1'b0); push_branch(1'b0);
        run_instr("bne_z1", OP_BNE, 6'h00, 1'b1);
        push_fetch(); push_decode(1'b0); push_branch(1'b1);
        run_instr("bne_z0", OP_BNE, 6'h00, 1'b0);

        push_fetch(); push_decode(1'b0); push_jump(1'b1);
        run_instr("jal", OP_JAL, 6'h00, 1'b0);
        push_fetch(); push_decode(1'b0); push_jump(1'b0);
        run_instr("j", OP_J, 6'h00, 1'b1);

        push_fetch(); push_decode(1'b0); push_exec(ALU_NOR);
        run_instr("nor", OP_RTYPE, FN_NOR, 1'b0);
        push_fetch(); push_decode(1'b0); push_exec(ALU_ADD);
        run_instr("addu", OP_RTYPE, FN_ADDU, 1'b0);
        push_fetch(); push_decode(1'b0); push_exec(ALU_SLTU);
        run_instr("sltu", OP_RTYPE, FN_SLTU, 1'b0);
        push_fetch(); push_decode(1'b1);
        run_instr("bad_funct", OP_RTYPE, 6'h3F, 1'b0);
        push_fetch(); push_decode(1'b1);
        run_instr("bad_op", 6'h3F, 6'h21, 1'b1);

        push_fetch(); push_decode(1'b0); push_iexec(ALU_OR, 1'b0);
        run_instr("ori", OP_ORI, 6'h00, 1'b0);
        push_fetch(); push_decode(1'b0); push_iexec(ALU_ADD, 1'b1);
        run_instr("addi", OP_ADDI, 6'h00, 1'b0);
        push_fetch(); push_decode(1'b0); push_iexec(ALU_SLT, 1'b1);
        run_instr("slti", OP_SLTI, 6'h00, 1'b0);
        push_fetch(); push_decode(1'b0); push_iexec(ALU_AND, 1'b0);
        run_instr("andi", OP_ANDI, 6'h00, 1'b0);

        // sw interrupted by reset in its MEMWR cycle.
        push_fetch(); push_decode(1'b0); push_memadr();
        run_instr("sw", OP_SW, 6'h00, 1'b0);
        rst = 1'b1;
        #1;
        check_state("sw_rst_memwr", 4'd5);
        check_rst_quiet("sw_rst_memwr");
        @(posedge clk);
        #1;
        check_state("sw_rst_after", 4'd0);
        rst = 1'b0;

        push_fetch(); push_decode(1'b0); push_jump(1'b0);
        run_instr("j_after_rst", OP_J, 6'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
